vlsu_cam_ordered: RTL
=====================

VLSU_CAM_ORDERED -- requirements
Module: vlsu_cam_ordered

Interface
REQ-001 The block SHALL have parameter WIDTH, default 50, meaning stored/search data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 32, meaning number of entries; power of two, at least 4.
REQ-003 The block SHALL have parameter WRITE, default 2, meaning number of write ports.
REQ-004 The block SHALL have parameter READ, default 3, meaning number of search ports.
REQ-005 The block SHALL have parameter ORDER, default 0, meaning match priority: 0 = oldest-first from head_i, 1 = youngest-first from head_i-1 downward.
REQ-006 The block SHALL have the following ports (ADDRESS = $clog2(DEPTH)):
- clk  in  1  single clock, rising edge.
- arst_n  in  1  asynchronous active-low reset.
- rst  in  1  synchronous flush, active high.
- head_i  in  ADDRESS  oldest-entry pointer for priority.
- enable_i  in  READ x DEPTH  per-search-port entry compare enable.
- write_i  in  WRITE  write request per port.
- write_addr_i  in  WRITE x ADDRESS  write address.
- write_data_i  in  WRITE x WIDTH  write data.
- clear_i  in  1  invalidate request.
- clear_addr_i  in  ADDRESS  entry to invalidate.
- read_i  in  READ  search request per port.
- read_data_i  in  READ x WIDTH  search key.
- match_o  out  READ  registered hit flag.
- match_data_o  out  READ x ADDRESS  registered index of the winning entry.
- multi_o  out  READ  registered flag: more than one entry hit.

Function
REQ-007 Each entry SHALL hold WIDTH data bits plus one valid bit; a write sets valid and loads data at the rising clk edge.
REQ-008 clear_i SHALL reset the valid bit of clear_addr_i at the edge; data is left unchanged.
REQ-009 If clear and write target the same entry in the same cycle, the write SHALL win (entry valid, new data).
REQ-010 If two write ports target the same entry in the same cycle, the highest-index port SHALL win.
REQ-011 An entry SHALL hit on port r when it is valid, enable_i[r][entry]=1, and data equals read_data_i[r] on all bits.
REQ-012 With ORDER=0 the winner SHALL be the first hit scanning head_i, head_i+1, ... modulo DEPTH.
REQ-013 With ORDER=1 the winner SHALL be the first hit scanning head_i-1, head_i-2, ... modulo DEPTH.
REQ-014 Search latency SHALL be one cycle: outputs registered at the edge after the cycle in which read_i[r]=1.
REQ-015 A search SHALL see storage as it was before the edge; a same-cycle write to a matching entry is not visible.
REQ-016 On a miss or when read_i[r]=0, the next cycle SHALL show match_o[r]=0, match_data_o[r]=0, multi_o[r]=0.
REQ-017 All search ports SHALL operate independently and concurrently, with no back-pressure or stall.

Reset
REQ-018 On arst_n=0, asynchronously: all valid bits SHALL be 0, and match_o, match_data_o and multi_o SHALL be 0; data storage is not reset.
REQ-019 On rst=1 at an edge:
- all valid bits SHALL be cleared;
- all outputs SHALL be zeroed;
- writes, clears and searches in that cycle SHALL be ignored.
REQ-020 Release of arst_n mid-stream SHALL take effect on the first following edge with no spurious hit.

Structure
REQ-021 The typedefs width_t, addr_t, depth_t, write_t and read_t SHALL live in shared package vlsu_cam_pkg, parametrised through module parameters.
REQ-022 The head-relative rotating priority encoder SHALL be a sub-module vlsu_cam_prio_enc (inputs: hit vector, head, ORDER; outputs: index, any, multi), instantiated READ times.

Verification
REQ-023 The bench SHALL write entries 0..31 with data 1..32 using both write ports (even/odd), search port 0 for keys 32..1, and see match_o=1 with match_data_o=31..0 one cycle later.
REQ-024 The bench SHALL search keys 68 and 69 (never written) and see match_o=0 and match_data_o=0.
REQ-025 The bench SHALL write data 7 to entries 3, 10 and 20:
- head_i=12, ORDER=0: index 20, multi_o=1;
- head_i=12, ORDER=1: index 10;
- head_i=4, ORDER=0: index 10.
REQ-026 The bench SHALL clear entry 5 and, in the same cycle, port-1-write entry 5 with data 99; a search for 99 the next cycle returns 5. The bench SHALL also write entry 6 on both ports with 11 and 12; a search for 12 hits 6 and a search for 11 misses.
REQ-027 The bench SHALL search key 9 on entry 8 (data 9) while enable_i[0][8]=0, and see a miss on port 0, while port 2 with full enable hits 8.
REQ-028 The bench SHALL pulse rst, then arst_n, with all entries valid, and see outputs 0 and every subsequent search miss until rewritten.

Source files
------------

// File: rtl/vlsu_cam_pkg.sv
// Shared types and default geometry for the ordered CAM.
// The top's parameters default to these values, so the typedefs describe the default build.
package vlsu_cam_pkg;

    localparam int CAM_WIDTH   = 50;
    localparam int CAM_DEPTH   = 32;
    localparam int CAM_WRITE   = 2;
    localparam int CAM_READ    = 3;
    localparam int CAM_ADDRESS = $clog2(CAM_DEPTH);

    localparam int ORDER_OLDEST   = 0;
    localparam int ORDER_YOUNGEST = 1;

    typedef logic [CAM_WIDTH-1:0]   width_t;
    typedef logic [CAM_ADDRESS-1:0] addr_t;
    typedef logic [CAM_DEPTH-1:0]   depth_t;
    typedef logic [CAM_WRITE-1:0]   write_t;
    typedef logic [CAM_READ-1:0]    read_t;

endpackage

// File: rtl/vlsu_cam_prio_enc.sv
// Head-relative rotating priority encoder: picks the first hit scanning up from head
// (oldest-first) or down from head-1 (youngest-first), plus any/multi flags.
module vlsu_cam_prio_enc
    import vlsu_cam_pkg::*;
#(
    parameter  int DEPTH   = CAM_DEPTH,
    parameter  int ORDER   = ORDER_OLDEST,
    localparam int ADDRESS = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]   i_hit,
    input  logic [ADDRESS-1:0] i_head,
    output logic [ADDRESS-1:0] o_index,
    output logic               o_any,
    output logic               o_multi
);

    logic [ADDRESS-1:0] w_pos;
    logic               w_found;

    // DEPTH is a power of two, so pointer arithmetic wraps for free.
    always_comb begin
        w_pos   = '0;
        w_found = 1'b0;
        o_index = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ORDER == ORDER_OLDEST)
                w_pos = i_head + ADDRESS'(i);
            else
                w_pos = i_head - ADDRESS'(i + 1);
            if (!w_found && i_hit[w_pos]) begin
                w_found = 1'b1;
                o_index = w_pos;
            end
        end
    end

    assign o_any   = |i_hit;
    assign o_multi = |(i_hit & (i_hit - DEPTH'(1)));

endmodule

// File: rtl/vlsu_cam_ordered.sv
// Multi-port CAM with per-port entry enables and head-relative match priority.
// Searches see pre-edge storage; results are registered one cycle later.
module vlsu_cam_ordered
    import vlsu_cam_pkg::*;
#(
    parameter  int WIDTH   = CAM_WIDTH,
    parameter  int DEPTH   = CAM_DEPTH,
    parameter  int WRITE   = CAM_WRITE,
    parameter  int READ    = CAM_READ,
    parameter  int ORDER   = ORDER_OLDEST,
    localparam int ADDRESS = $clog2(DEPTH)
) (
    input  logic                            clk,
    input  logic                            arst_n,
    input  logic                            rst,
    input  logic [ADDRESS-1:0]              head_i,
    input  logic [READ-1:0][DEPTH-1:0]      enable_i,
    input  logic [WRITE-1:0]                write_i,
    input  logic [WRITE-1:0][ADDRESS-1:0]   write_addr_i,
    input  logic [WRITE-1:0][WIDTH-1:0]     write_data_i,
    input  logic                            clear_i,
    input  logic [ADDRESS-1:0]              clear_addr_i,
    input  logic [READ-1:0]                 read_i,
    input  logic [READ-1:0][WIDTH-1:0]      read_data_i,
    output logic [READ-1:0]                 match_o,
    output logic [READ-1:0][ADDRESS-1:0]    match_data_o,
    output logic [READ-1:0]                 multi_o
);

    logic [WIDTH-1:0]               r_data [DEPTH];
    logic [DEPTH-1:0]               r_valid;
    logic [READ-1:0]                r_match;
    logic [READ-1:0][ADDRESS-1:0]   r_match_data;
    logic [READ-1:0]                r_multi;

    logic [READ-1:0][DEPTH-1:0]     w_hit;
    logic [READ-1:0][ADDRESS-1:0]   w_idx;
    logic [READ-1:0]                w_any;
    logic [READ-1:0]                w_multi;

    // Clear is applied first so a same-entry write overrides it; later write ports override earlier ones.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_valid <= '0;
        end else if (rst) begin
            r_valid <= '0;
        end else begin
            if (clear_i)
                r_valid[clear_addr_i] <= 1'b0;
            for (int w = 0; w < WRITE; w++)
                if (write_i[w])
                    r_valid[write_addr_i[w]] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int w = 0; w < WRITE; w++)
                if (write_i[w])
                    r_data[write_addr_i[w]] <= write_data_i[w];
        end
    end

    for (genvar r = 0; r < READ; r++) begin : g_port
        for (genvar e = 0; e < DEPTH; e++) begin : g_ent
            assign w_hit[r][e] = r_valid[e] & enable_i[r][e] & (r_data[e] == read_data_i[r]);
        end

        vlsu_cam_prio_enc #(
            .DEPTH (DEPTH),
            .ORDER (ORDER)
        ) u_prio (
            .i_hit   (w_hit[r]),
            .i_head  (head_i),
            .o_index (w_idx[r]),
            .o_any   (w_any[r]),
            .o_multi (w_multi[r])
        );
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_match      <= '0;
            r_match_data <= '0;
            r_multi      <= '0;
        end else if (rst) begin
            r_match      <= '0;
            r_match_data <= '0;
            r_multi      <= '0;
        end else begin
            for (int r = 0; r < READ; r++) begin
                r_match[r]      <= read_i[r] & w_any[r];
                r_match_data[r] <= (read_i[r] & w_any[r]) ? w_idx[r] : '0;
                r_multi[r]      <= read_i[r] & w_multi[r];
            end
        end
    end

    assign match_o      = r_match;
    assign match_data_o = r_match_data;
    assign multi_o      = r_multi;

endmodule
